// File: rtl/hs_sink_buf.sv
// hs_sink_buf -- parametrised valid/ready terminal sink with drainable FIFO.
//
// Accepted beats (valid_i && ready_o) are written into a DEPTH-entry FIFO
// that is popped by drain_i. ready_o is registered and derived from the
// post-update occupancy and a per-mode gate, so overflow cannot occur.
//
// Parameters:
//   DATA_W    payload width
//   DEPTH     FIFO entries (power of two, >= 2)
//   MODE      ready gate: 0 = always, 1 = random_stall (registered), 2 = LFSR bit 0
//   LFSR_SEED nonzero reset value of the 16-bit LFSR
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   random_stall        external ready gate (MODE 1)
//   valid_i, data_i     upstream beat
//   ready_o             registered ready to upstream
//   drain_i             pop request
//   dout_o,dout_valid_o popped data, valid for one cycle
//   level_o             FIFO occupancy
//   beat_cnt_o          accepted beat count (wraps)
//   err_o, err_cnt_o    sticky sequence error and saturating error count
//
// Optional feature: define HS_SINK_CHECK_EN to compile in the sequence
// checker (each beat must equal previous beat + 1, first expected is 0).
// Without it err_o and err_cnt_o are tied to 0.

module hs_sink_buf #(
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 4,
  parameter int          MODE      = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       random_stall,
  input  logic                       valid_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       ready_o,
  input  logic                       drain_i,
  output logic [DATA_W-1:0]          dout_o,
  output logic                       dout_valid_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [31:0]                beat_cnt_o,
  output logic                       err_o,
  output logic [15:0]                err_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [15:0]       lfsr;

  logic              push;
  logic              pop;
  logic              gate;
  logic [LVL_W-1:0]  level_next;

  always_comb begin
    push       = valid_i & ready_o;
    pop        = drain_i & (level_o != '0);
    level_next = level_o + LVL_W'(push) - LVL_W'(pop);
    gate       = lfsr[0];
    if (MODE == 0)
      gate = 1'b1;
    else if (MODE == 1)
      gate = random_stall;
  end

  // Control, counters and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_o      <= 1'b0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      level_o      <= '0;
      beat_cnt_o   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lfsr         <= LFSR_SEED;
    end else begin
      lfsr         <= lfsr_step(lfsr);
      ready_o      <= (level_next < FULL_LVL) && gate;
      level_o      <= level_next;
      dout_valid_o <= pop;
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        beat_cnt_o <= beat_cnt_o + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        dout_o <= mem[rd_ptr];
      end
    end
  end

  // Storage needs no reset: contents are only read behind a valid level.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= data_i;
  end

`ifdef HS_SINK_CHECK_EN
  logic [DATA_W-1:0] expected;

  // Resync to data_i + 1 after every beat so one bad beat costs one error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected  <= '0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else if (push) begin
      expected <= data_i + DATA_W'(1);
      if (data_i != expected) begin
        err_o     <= 1'b1;
        err_cnt_o <= sat_inc16(err_cnt_o);
      end
    end
  end
`else
  assign err_o     = 1'b0;
  assign err_cnt_o = '0;
`endif

endmodule
